// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_arb_pkg
// Brief  : Shared types for the bus host arbiter. Defines the two-state
//          arbitration FSM encoding used by bus_host_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package bus_arb_pkg;

    // ArbIdle    : free round-robin pick among requesting hosts
    // ArbWaitGnt : a host was offered downstream but not yet granted; the
    //              selection is frozen on that host until it is granted or
    //              it withdraws its request
    typedef enum logic [0:0] {
        ArbIdle    = 1'b0,
        ArbWaitGnt = 1'b1
    } arb_state_e;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module : bus_arb_order_fifo
// Brief  : Small synchronous FIFO holding the host index of every granted
//          but not yet answered access, so responses can be routed back in
//          issue order.
// Ports  : clk_i   clock
//          rst_i   asynchronous active-high reset (empties the FIFO)
//          push_i  write data_i at the tail (ignored when full)
//          data_i  host index to store
//          pop_i   drop the head entry (ignored when empty)
//          full_o  count == Depth
//          empty_o count == 0
//          head_o  oldest stored host index
// Rev    : 1.0  initial release
// ============================================================================
module bus_arb_order_fifo #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : bus_arb_order_fifo
`default_nettype wire

// File: rtl/bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_host_arbiter
// Brief  : Round-robin arbiter sharing one req/gnt/rvalid device port among
//          NrHosts hosts. Grants pass through with zero latency; responses
//          are steered back to the issuing host through an in-order ID FIFO.
// Ports  : clk_i / rst_i            clock, asynchronous active-high reset
//          host_req_i/host_gnt_o    per-host request / grant
//          host_addr_i/we/be/wdata  per-host access fields
//          host_rvalid_o/rdata/err  per-host response (issuing host only)
//          dev_req_o/dev_gnt_i      downstream request / grant
//          dev_addr_o/we/be/wdata   fields of the selected host
//          dev_rvalid_i/rdata/err   downstream response
//          protocol_err_o           sticky: stray rvalid or req dropped early
// Rev    : 1.0  initial release
// ============================================================================
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts-1:0][AddrWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic                                  dev_req_o,
    input  logic                                  dev_gnt_i,
    output logic [AddrWidth-1:0]                  dev_addr_o,
    output logic                                  dev_we_o,
    output logic [DataWidth/8-1:0]                dev_be_o,
    output logic [DataWidth-1:0]                  dev_wdata_o,
    input  logic                                  dev_rvalid_i,
    input  logic [DataWidth-1:0]                  dev_rdata_i,
    input  logic                                  dev_err_i,
    output logic                                  protocol_err_o
);

    localparam int HostIdxW = $clog2(NrHosts);

    arb_state_e            state_q, state_d;
    logic [HostIdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HostIdxW-1:0]   lock_idx_q, lock_idx_d;
    logic                  perr_q, perr_d;

    logic [HostIdxW-1:0]   w_rr_sel;
    logic [HostIdxW-1:0]   w_cand;
    logic                  w_found;
    int                    w_cand_int;
    logic [HostIdxW-1:0]   w_sel;
    logic                  w_dev_req;
    logic                  w_grant;
    logic                  w_pop;
    logic                  w_stray;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [HostIdxW-1:0]   w_fifo_head;

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting host at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_sel   = rr_ptr_q;
        w_found    = 1'b0;
        w_cand_int = 0;
        w_cand     = '0;
        for (int i = 0; i < NrHosts; i++) begin
            w_cand_int = int'(rr_ptr_q) + i;
            if (w_cand_int >= NrHosts) begin
                w_cand_int = w_cand_int - NrHosts;
            end
            w_cand = HostIdxW'(w_cand_int);
            if (!w_found && host_req_i[w_cand]) begin
                w_found  = 1'b1;
                w_rr_sel = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM: next state, pointer and error tracking.
    // The full check uses the registered count only, so a response popping
    // the FIFO this cycle does not free a slot until the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        perr_d     = perr_q;
        w_sel      = w_rr_sel;
        w_dev_req  = 1'b0;

        case (state_q)
            ArbIdle: begin
                w_sel     = w_rr_sel;
                w_dev_req = (|host_req_i) & ~w_fifo_full;
            end
            ArbWaitGnt: begin
                // Once offered downstream, the access must not change
                // under the device, so priority is frozen on lock_idx.
                w_sel     = lock_idx_q;
                w_dev_req = host_req_i[lock_idx_q] & ~w_fifo_full;
            end
            default: begin
                w_sel     = w_rr_sel;
                w_dev_req = 1'b0;
            end
        endcase

        w_grant = w_dev_req & dev_gnt_i;

        if (w_grant) begin
            rr_ptr_d = (w_sel == HostIdxW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
            state_d  = ArbIdle;
        end else if ((state_q == ArbIdle) && w_dev_req) begin
            lock_idx_d = w_sel;
            state_d    = ArbWaitGnt;
        end else if ((state_q == ArbWaitGnt) && !host_req_i[lock_idx_q]) begin
            perr_d  = 1'b1;
            state_d = ArbIdle;
        end

        if (w_stray) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ArbIdle;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            perr_q     <= perr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-access order tracking.
    // ------------------------------------------------------------------
    assign w_pop   = dev_rvalid_i & ~w_fifo_empty;
    assign w_stray = dev_rvalid_i &  w_fifo_empty;

    bus_arb_order_fifo #(
        .Width (HostIdxW),
        .Depth (MaxOutstanding)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_fifo_head)
    );

    // ------------------------------------------------------------------
    // Request mux and response demux. Everything is forced to zero while
    // reset is asserted, because these paths are combinational from the
    // inputs and would otherwise leak through during reset.
    // ------------------------------------------------------------------
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        if (!rst_i) begin
            dev_req_o          = w_dev_req;
            dev_addr_o         = host_addr_i[w_sel];
            dev_we_o           = host_we_i[w_sel];
            dev_be_o           = host_be_i[w_sel];
            dev_wdata_o        = host_wdata_i[w_sel];
            host_gnt_o[w_sel]  = w_grant;
            if (w_pop) begin
                host_rvalid_o[w_fifo_head] = 1'b1;
                host_rdata_o[w_fifo_head]  = dev_rdata_i;
                host_err_o[w_fifo_head]    = dev_err_i;
            end
        end
    end

    assign protocol_err_o = perr_q;

endmodule : bus_host_arbiter
`default_nettype wire
